// File: rtl/wishbone_master.sv
// Wishbone classic single-cycle initiator: turns one valid/ready request into one
// bus read or write and reports the result, including bus errors and timeouts, on a one-cycle strobe.
module wishbone_master #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int TIMEOUT       = 255,
  parameter int TIMER_WIDTH   = 8
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err,
  output logic                     CYC_O,
  output logic                     STB_O,
  output logic                     WE_O,
  output logic [ADDRESS_WIDTH-1:0] ADR_O,
  output logic [DATA_WIDTH-1:0]    DAT_O,
  input  logic [DATA_WIDTH-1:0]    DAT_I,
  input  logic                     ACK_I,
  input  logic                     ERR_I
);

  typedef enum logic {IDLE, BUS} state_e;

  localparam bit TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST =
    TIMEOUT_EN ? TIMER_WIDTH'(TIMEOUT - 1) : '0;

  state_e                   state_q, state_d;
  logic                     stb_q, stb_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0]    dat_q, dat_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                     rsp_err_q, rsp_err_d;
  logic [TIMER_WIDTH-1:0]   timer_q, timer_d;
  logic                     timed_out;
  logic                     done;

  assign timed_out = TIMEOUT_EN && (timer_q == TIMER_LAST);

  always_comb begin
    state_d     = state_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    timer_d     = timer_q;
    done        = 1'b0;

    case (state_q)
      // ACK_I/ERR_I are deliberately ignored here so a late registered ACK
      // from the previous cycle cannot complete the next transaction.
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          adr_d   = req_addr;
          dat_d   = req_wdata;
          stb_d   = 1'b1;
          timer_d = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        if (timer_q != '1) timer_d = timer_q + 1'b1;
        if (ERR_I) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          done        = 1'b1;
        end else if (ACK_I) begin
          rsp_err_d = 1'b0;
          if (!we_q) rsp_rdata_d = DAT_I;
          done = 1'b1;
        end else if (timed_out) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          done        = 1'b1;
        end
        if (done) begin
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q     <= IDLE;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      timer_q     <= timer_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign CYC_O     = stb_q;
  assign STB_O     = stb_q;
  assign WE_O      = we_q;
  assign ADR_O     = adr_q;
  assign DAT_O     = dat_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wishbone_master.sv
// Randomized bench for wishbone_master: a RAM-like responder with variable ACK latency,
// errors and stale ACKs, checked every cycle against a transaction-level model.
module tb_wishbone_master;
  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  logic       req_valid, req_ready, req_we;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       cyc_o, stb_o, we_o;
  logic [7:0] adr_o, dat_o, dat_i;
  logic       ack_i, err_i;

  logic       req0_valid, req0_ready, rsp0_valid, rsp0_err, cyc0_o, stb0_o, we0_o;
  logic [7:0] rsp0_rdata, adr0_o, dat0_o;

  wishbone_master #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT(TMO), .TIMER_WIDTH(8)) u_dut (
    .CLK_I(clk), .RST_I(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .CYC_O(cyc_o), .STB_O(stb_o), .WE_O(we_o), .ADR_O(adr_o), .DAT_O(dat_o),
    .DAT_I(dat_i), .ACK_I(ack_i), .ERR_I(err_i)
  );

  wishbone_master #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT(0), .TIMER_WIDTH(8)) u_dut_noto (
    .CLK_I(clk), .RST_I(rst),
    .req_valid(req0_valid), .req_ready(req0_ready), .req_we(1'b0),
    .req_addr(8'h33), .req_wdata(8'h00),
    .rsp_valid(rsp0_valid), .rsp_rdata(rsp0_rdata), .rsp_err(rsp0_err),
    .CYC_O(cyc0_o), .STB_O(stb0_o), .WE_O(we0_o), .ADR_O(adr0_o), .DAT_O(dat0_o),
    .DAT_I(8'h00), .ACK_I(1'b0), .ERR_I(1'b0)
  );

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  bit          chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Transaction-level reference: one outstanding transaction described by its
  // start cycle and bus duration; the outputs in any cycle follow from that.
  logic [7:0]  ref_mem [256];
  bit          have_txn;
  int unsigned tx_start, tx_d;
  logic        tx_we, tx_er, tx_prev_er, last_er;
  logic [7:0]  tx_addr, tx_wdata, tx_rd, tx_prev_rd, last_rd;

  function automatic void model_reset();
    have_txn = 1'b0;
    last_rd  = 8'h00;
    last_er  = 1'b0;
  endfunction

  function automatic void plan(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                               input int unsigned lat, input bit errf);
    tx_start = cyc + 1;
    tx_we = we; tx_addr = addr; tx_wdata = wdata;
    if (lat != 0 && lat <= TMO) begin
      tx_d = lat;  tx_er = errf;
    end else begin
      tx_d = TMO;  tx_er = 1'b1;
    end
    tx_prev_rd = last_rd;
    tx_prev_er = last_er;
    if (tx_er) tx_rd = 8'h00;
    else if (we) begin
      tx_rd = last_rd;
      ref_mem[addr] = wdata;
    end else tx_rd = ref_mem[addr];
    last_rd = tx_rd; last_er = tx_er; have_txn = 1'b1;
  endfunction

  logic       e_rdy, e_stb, e_we, e_rv, e_er;
  logic [7:0] e_adr, e_dat, e_rd;

  initial forever begin
    @(posedge clk);
    #1;
    if (chk_en) begin
      if (!have_txn) begin
        e_rdy = 1; e_stb = 0; e_we = 0; e_adr = 0; e_dat = 0; e_rv = 0; e_rd = 0; e_er = 0;
      end else if (cyc < tx_start + tx_d) begin
        e_rdy = 0; e_stb = 1; e_we = tx_we; e_adr = tx_addr; e_dat = tx_wdata;
        e_rv = 0; e_rd = tx_prev_rd; e_er = tx_prev_er;
      end else begin
        e_rdy = 1; e_stb = 0; e_we = tx_we; e_adr = tx_addr; e_dat = tx_wdata;
        e_rv = (cyc == tx_start + tx_d); e_rd = tx_rd; e_er = tx_er;
      end
      chk("req_ready", req_ready, e_rdy);
      chk("CYC_O", cyc_o, e_stb);
      chk("STB_O", stb_o, e_stb);
      chk("WE_O", we_o, e_we);
      chk("ADR_O", adr_o, e_adr);
      chk("DAT_O", dat_o, e_dat);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("rsp_rdata", rsp_rdata, e_rd);
      chk("rsp_err", rsp_err, e_er);
    end
  end

  // Responder: acknowledges in the lat-th cycle STB_O is high (0 = never),
  // optionally with ERR_I, optionally holding ACK_I one cycle after STB_O drops.
  logic [7:0]  rmem [256];
  int unsigned r_lat = 0, scnt = 0;
  bit          r_err = 0, r_stale = 0, stale_pend = 0, hit;

  task automatic tick();
    @(negedge clk);
    if (stb_o) begin
      scnt++;
      hit   = (r_lat != 0) && (scnt == r_lat);
      ack_i = hit;
      err_i = hit && r_err;
      if (r_err) dat_i = 8'h5A;
      else if (hit && !we_o) dat_i = rmem[adr_o];
      else dat_i = 8'($urandom);
      if (hit && we_o && !r_err) rmem[adr_o] = dat_o;
      stale_pend = hit && r_stale;
    end else begin
      scnt = 0;
      ack_i = stale_pend;
      err_i = 1'b0;
      stale_pend = 1'b0;
      dat_i = 8'($urandom);
    end
  endtask

  // Called at a negedge where the master is idle; returns at the negedge of the
  // response cycle so a following call issues back-to-back.
  task automatic do_txn(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                        input int unsigned lat, input bit errf, input bit stale,
                        output int unsigned rsp_cyc, output int unsigned stb_cyc);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    r_lat = lat; r_err = errf; r_stale = stale;
    plan(we, addr, wdata, lat, errf);
    stb_cyc = tx_start;
    tick();
    while (cyc < tx_start + tx_d) begin
      req_valid = 1'($urandom);
      req_we    = 1'($urandom);
      req_addr  = 8'($urandom);
      req_wdata = 8'($urandom);
      tick();
    end
    req_valid = 1'b0;
    rsp_cyc = cyc;
  endtask

  initial begin
    int unsigned rc, sc, rc1, sc1, lat, gap, hi_cnt, rsp_cnt;
    rst = 1'b1;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
    req0_valid = 0; ack_i = 0; err_i = 0; dat_i = 0;
    for (int i = 0; i < 256; i++) begin
      rmem[i] = 8'($urandom);
      ref_mem[i] = rmem[i];
    end
    model_reset();
    repeat (3) tick();
    chk("reset_req_ready", req_ready, 1);
    chk("reset_stb", stb_o, 0);
    chk("reset_cyc", cyc_o, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    do_txn(1'b1, 8'h10, 8'hA5, 2, 0, 0, rc1, sc1);
    chk("wr_latency", rc1 - sc1, 2);
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_err", rsp_err, 0);
    chk("stb_low_between", stb_o, 0);
    do_txn(1'b0, 8'h10, 8'h00, 2, 0, 0, rc, sc);
    chk("rd_latency", rc - sc, 2);
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_err", rsp_err, 0);
    chk("rd_rsp_rdata", rsp_rdata, 8'hA5);

    do_txn(1'b1, 8'h30, 8'h77, 2, 0, 1, rc, sc);
    do_txn(1'b0, 8'h10, 8'h00, 3, 0, 0, rc, sc);
    chk("stale_latency", rc - sc, 3);
    chk("stale_rsp_valid", rsp_valid, 1);
    chk("stale_rsp_rdata", rsp_rdata, 8'hA5);

    do_txn(1'b0, 8'h20, 8'h00, 2, 1, 0, rc, sc);
    chk("err_rsp_valid", rsp_valid, 1);
    chk("err_rsp_err", rsp_err, 1);
    chk("err_rsp_rdata", rsp_rdata, 8'h00);

    tick();
    do_txn(1'b0, 8'h40, 8'h00, 0, 0, 0, rc, sc);
    chk("timeout_stb_cycles", rc - sc, 4);
    chk("timeout_rsp_valid", rsp_valid, 1);
    chk("timeout_rsp_err", rsp_err, 1);

    repeat (200) begin
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      case ($urandom_range(0, 9))
        0:       lat = 0;
        9:       lat = 5;
        default: lat = $urandom_range(1, 4);
      endcase
      do_txn(1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom), lat,
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), rc, sc);
    end

    tick();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h55; req_wdata = 8'h00;
    r_lat = 0; r_err = 0; r_stale = 0;
    plan(1'b0, 8'h55, 8'h00, 0, 0);
    tick();
    req_valid = 1'b0;
    tick();
    chk("pre_reset_stb", stb_o, 1);
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("reset_async_cyc", cyc_o, 0);
    chk("reset_async_stb", stb_o, 0);
    chk("reset_async_rsp_valid", rsp_valid, 0);
    repeat (2) begin
      tick();
      chk("reset_hold_rsp_valid", rsp_valid, 0);
    end
    rst = 1'b0;
    model_reset();
    #1;
    chk("post_reset_req_ready", req_ready, 1);
    chk_en = 1'b1;
    repeat (2) tick();
    do_txn(1'b0, 8'h10, 8'h00, 2, 0, 0, rc, sc);
    chk("post_reset_rd_rdata", rsp_rdata, 8'hA5);

    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    hi_cnt = 0; rsp_cnt = 0;
    repeat (1000) begin
      tick();
      if (stb0_o) hi_cnt++;
      if (rsp0_valid) rsp_cnt++;
    end
    chk("noto_stb_cycles", hi_cnt, 1000);
    chk("noto_rsp_count", rsp_cnt, 0);
    chk("noto_req_ready", req0_ready, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wishbone_master.md
Name: wishbone_master

Overview:
- Wishbone classic single-cycle initiator.
- Converts a simple valid/ready request from the core's load/store path into one Wishbone read or write cycle.
- Returns the result on a one-cycle response strobe.
- Sits between the CPU data/instruction port and Wishbone responders such as the on-chip RAM. Adds bus-error and timeout reporting.

Parameters:
- ADDRESS_WIDTH, 8, width of req_addr and ADR_O
- DATA_WIDTH, 8, width of all data paths
- TIMEOUT, 255, cycles to wait for ACK_I/ERR_I after STB_O rises; 0 disables the timeout
- TIMER_WIDTH, 8, counter width; must hold TIMEOUT

Ports:
- CLK_I  in  1  clock, rising edge
- RST_I  in  1  reset, asynchronous, active-high
- req_valid  in  1  core request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDRESS_WIDTH  target address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle pulse: transaction finished
- rsp_rdata  out  DATA_WIDTH  read data; valid with rsp_valid on reads
- rsp_err  out  1  qualifies rsp_valid: ERR_I or timeout
- CYC_O  out  1  bus cycle active
- STB_O  out  1  strobe
- WE_O  out  1  write enable
- ADR_O  out  ADDRESS_WIDTH  address
- DAT_O  out  DATA_WIDTH  write data
- DAT_I  in  DATA_WIDTH  read data from responder
- ACK_I  in  1  responder acknowledge
- ERR_I  in  1  responder error

Behaviour:
- Reset (asynchronous, RST_I=1): state IDLE, req_ready=1.
- Reset values of all other outputs: CYC_O=0, STB_O=0, WE_O=0, ADR_O=0, DAT_O=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timer=0.
- All outputs are registered. req_ready is decoded from state (1 only in IDLE).
- State IDLE:
  - req_ready=1.
  - On req_valid at an edge: latch req_we/req_addr/req_wdata into WE_O/ADR_O/DAT_O, set CYC_O=STB_O=1, clear timer, go to BUS.
  - ACK_I/ERR_I are ignored in IDLE. This tolerates responders with a registered ACK that stays high one cycle after STB falls.
- State BUS:
  - req_ready=0. CYC_O, STB_O, WE_O, ADR_O, DAT_O held stable. Timer increments each cycle.
  - Exit conditions, sampled at an edge, in priority order:
    1. ERR_I=1: rsp_err=1, rsp_rdata=0.
    2. ACK_I=1: rsp_err=0; on a read rsp_rdata<=DAT_I, on a write rsp_rdata is unchanged.
    3. TIMEOUT!=0 and timer==TIMEOUT-1: rsp_err=1, rsp_rdata=0.
  - On any exit at that edge: CYC_O=STB_O=0, rsp_valid=1, go to IDLE.
- rsp_valid is high for exactly one cycle, the first cycle back in IDLE. rsp_rdata and rsp_err hold until the next response.
- Back-to-back: a new request may be accepted in the same cycle rsp_valid is high.
  - STB_O therefore deasserts for at least one cycle between transactions.
  - Minimum period is 3 cycles per transaction with a 1-cycle-ACK responder.
- Latency: request accept edge to rsp_valid = (responder ACK latency + 1) cycles after STB_O rises.
- Requests arriving while in BUS are not accepted (req_ready=0). The core must hold req_valid and its fields until accepted.
- Reset asserted mid-BUS: CYC_O/STB_O drop immediately (asynchronously), no rsp_valid is generated, and the pending transaction is lost.
- Timer saturates at TIMER_WIDTH; it never wraps.

Test Plan:
- Write then read with the RAM responder (1-cycle registered ACK): write addr 0x10 data 0xA5, then read 0x10.
  - Required: each rsp_valid occurs 2 cycles after STB_O rises, rsp_err=0, read rsp_rdata=0xA5.
  - Required: STB_O low for ≥1 cycle between the two transactions.
- Stale ACK: responder holds ACK_I one extra cycle after STB_O falls while the next request is issued immediately.
  - Required: the second transaction completes only on its own ACK; no spurious rsp_valid.
- Error: responder asserts ERR_I and ACK_I together on a read of 0x20 with DAT_I=0x5A.
  - Required: rsp_valid=1, rsp_err=1, rsp_rdata=0x00.
- Timeout: TIMEOUT=4, responder never acks.
  - Required: STB_O high exactly 4 cycles, then rsp_valid=1 and rsp_err=1.
  - With TIMEOUT=0, STB_O stays high for 1000 cycles and no response is produced.
- Reset mid-transaction: assert RST_I 1 cycle after STB_O rises.
  - Required: CYC_O/STB_O fall before the next clock edge, no rsp_valid, req_ready=1 after release.
- Backpressure: hold req_valid high with changing req_addr while in BUS.
  - Required: ADR_O stays at the accepted value, and req_ready=0 until the response.
